// File: rtl/line_fill_unit.sv
// Cache line fill engine: an optional dirty-victim write-back burst, then a burst read of one line.
// Define LINE_FILL_WRITEBACK_EN to include the WB state; by default victims are never written back.
module line_fill_unit #(
  parameter int OFF_W = 3,
  parameter int IDX_W = 6,
  parameter int MAW   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            addr,
  input  logic                   wb_dirty,
  input  logic [31:0]            wb_addr,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [MAW-1:0]         mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  input  logic                   mem_ack,
  output logic [IDX_W+OFF_W-1:0] cache_addr,
  output logic [31:0]            cache_wdata,
  output logic                   cache_we,
  input  logic [31:0]            cache_rdata,
  output logic                   busy,
  output logic                   done
);

  localparam int BASE_W = MAW - OFF_W;

`ifdef LINE_FILL_WRITEBACK_EN
  typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic [BASE_W-1:0] base_q;
  logic [IDX_W-1:0]  idx_q;
  logic              load;
`ifdef LINE_FILL_WRITEBACK_EN
  logic [BASE_W-1:0] wb_base_q;
`endif

  // Only a slice of each address is meaningful; fold the rest away explicitly.
  logic unused_bits;
  assign unused_bits = ^{addr, wb_addr, wb_dirty};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      idx_q   <= '0;
`ifdef LINE_FILL_WRITEBACK_EN
      wb_base_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        base_q <= addr[MAW+1:OFF_W+2];
        idx_q  <= addr[IDX_W+OFF_W+1:OFF_W+2];
`ifdef LINE_FILL_WRITEBACK_EN
        wb_base_q <= wb_addr[MAW+1:OFF_W+2];
`endif
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load        = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    cache_addr  = '0;
    cache_wdata = '0;
    cache_we    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    // Outputs are forced quiet for the whole reset cycle, not just after it.
    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            load  = 1'b1;
            cnt_d = '0;
`ifdef LINE_FILL_WRITEBACK_EN
            state_d = wb_dirty ? S_WB : S_FILL;
`else
            state_d = S_FILL;
`endif
          end
        end
`ifdef LINE_FILL_WRITEBACK_EN
        S_WB: begin
          busy       = 1'b1;
          mem_req    = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = {wb_base_q, cnt_q};
          cache_addr = {idx_q, cnt_q};
          mem_wdata  = cache_rdata;
          if (mem_ack) begin
            cnt_d = cnt_q + OFF_W'(1);
            if (&cnt_q) state_d = S_FILL;
          end
        end
`endif
        S_FILL: begin
          busy        = 1'b1;
          mem_req     = 1'b1;
          mem_addr    = {base_q, cnt_q};
          cache_addr  = {idx_q, cnt_q};
          cache_wdata = mem_rdata;
          cache_we    = mem_ack;
          if (mem_ack) begin
            cnt_d = cnt_q + OFF_W'(1);
            if (&cnt_q) state_d = S_DONE;
          end
        end
        S_DONE: begin
          busy    = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule
